// File: rtl/skew_mon_pkg.sv
// Shared definitions for the skew-check controller: FSM encoding and default widths.
package skew_mon_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARMED_A = 2'd1,
      S_ARMED_B = 2'd2
   } skew_state_e;

   localparam int unsigned DEF_CNT_W  = 8;
   localparam int unsigned DEF_VCNT_W = 8;

endpackage

// File: rtl/edge_detect_prime.sv
// Rising-edge detector for a strobe already synchronous to clk. The first cycle after
// reset is masked so a strobe that is already high does not look like a fresh edge.
module edge_detect_prime (
   input  logic clk,
   input  logic reset_n,
   input  logic sig,
   output logic rise
);

   logic sig_q;
   logic primed_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sig_q    <= 1'b0;
         primed_q <= 1'b0;
      end else begin
         sig_q    <= sig;
         primed_q <= 1'b1;
      end
   end

   assign rise = primed_q & sig & ~sig_q;

endmodule

// File: rtl/skew_monitor_ctrl.sv
// Measures cycle distance between rising edges of sig_a and sig_b, compares it to a
// programmable limit and keeps a saturating violation count.
module skew_monitor_ctrl
   import skew_mon_pkg::*;
#(
   parameter int unsigned CNT_W  = DEF_CNT_W,
   parameter int unsigned VCNT_W = DEF_VCNT_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              enable,
   input  logic              sig_a,
   input  logic              sig_b,
   input  logic [CNT_W-1:0]  limit,
   input  logic              clear_cnt,
   output logic              skew_valid,
   output logic [CNT_W-1:0]  skew_value,
   output logic              skew_viol,
   output logic              lead_b,
   output logic              miss_pulse,
   output logic [VCNT_W-1:0] viol_count
);

   localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [VCNT_W-1:0] VCNT_MAX = {VCNT_W{1'b1}};
   localparam logic [VCNT_W-1:0] VCNT_ONE = VCNT_W'(1);

   skew_state_e       state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              edge_a, edge_b;

   logic              res_fire;
   logic              res_timeout;
   logic              res_lead_b;
   logic              res_viol;
   logic [CNT_W-1:0]  res_value;
   logic              miss_fire;

   logic              skew_valid_q;
   logic [CNT_W-1:0]  skew_value_q;
   logic              skew_viol_q;
   logic              lead_b_q;
   logic              miss_pulse_q;
   logic [VCNT_W-1:0] viol_count_q;

   edge_detect_prime u_edge_a (
      .clk     (clk),
      .reset_n (reset_n),
      .sig     (sig_a),
      .rise    (edge_a)
   );

   edge_detect_prime u_edge_b (
      .clk     (clk),
      .reset_n (reset_n),
      .sig     (sig_b),
      .rise    (edge_b)
   );

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state and skew counter
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!enable) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               cnt_d = '0;
               if (edge_a && !edge_b) begin
                  state_d = S_ARMED_A;
                  cnt_d   = CNT_ONE;
               end else if (edge_b && !edge_a) begin
                  state_d = S_ARMED_B;
                  cnt_d   = CNT_ONE;
               end
            end
            S_ARMED_A: begin
               if (edge_b) begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
               end else if (edge_a) begin
                  cnt_d = CNT_ONE;
               end else if (cnt_q == CNT_MAX) begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            S_ARMED_B: begin
               if (edge_a) begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
               end else if (edge_b) begin
                  cnt_d = CNT_ONE;
               end else if (cnt_q == CNT_MAX) begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Result decode; the closing edge wins over a re-fire of the leading strobe
   always_comb begin
      res_fire    = 1'b0;
      res_timeout = 1'b0;
      res_lead_b  = 1'b0;
      res_value   = cnt_q;
      miss_fire   = 1'b0;
      if (enable) begin
         case (state_q)
            S_IDLE: begin
               if (edge_a && edge_b) begin
                  res_fire  = 1'b1;
                  res_value = '0;
               end
            end
            S_ARMED_A: begin
               if (edge_b) begin
                  res_fire = 1'b1;
               end else if (edge_a) begin
                  miss_fire = 1'b1;
               end else if (cnt_q == CNT_MAX) begin
                  res_fire    = 1'b1;
                  res_timeout = 1'b1;
               end
            end
            S_ARMED_B: begin
               res_lead_b = 1'b1;
               if (edge_a) begin
                  res_fire = 1'b1;
               end else if (edge_b) begin
                  miss_fire = 1'b1;
               end else if (cnt_q == CNT_MAX) begin
                  res_fire    = 1'b1;
                  res_timeout = 1'b1;
               end
            end
            default: begin
               res_fire = 1'b0;
            end
         endcase
      end
      res_viol = res_timeout | (res_value > limit);
   end

   // Registered result, miss pulse and violation counter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         skew_valid_q <= 1'b0;
         skew_value_q <= '0;
         skew_viol_q  <= 1'b0;
         lead_b_q     <= 1'b0;
         miss_pulse_q <= 1'b0;
         viol_count_q <= '0;
      end else begin
         skew_valid_q <= res_fire;
         miss_pulse_q <= miss_fire;
         if (res_fire) begin
            skew_value_q <= res_value;
            skew_viol_q  <= res_viol;
            lead_b_q     <= res_lead_b;
         end
         if (clear_cnt) begin
            viol_count_q <= '0;
         end else if (res_fire && res_viol && (viol_count_q != VCNT_MAX)) begin
            viol_count_q <= viol_count_q + VCNT_ONE;
         end
      end
   end

   assign skew_valid = skew_valid_q;
   assign skew_value = skew_value_q;
   assign skew_viol  = skew_viol_q;
   assign lead_b     = lead_b_q;
   assign miss_pulse = miss_pulse_q;
   assign viol_count = viol_count_q;

endmodule

// File: tb/tb_skew_monitor_ctrl.sv
// Self-checking bench for skew_monitor_ctrl: an 8-bit and a 4-bit counter instance,
// expected results queued at stimulus time and matched when skew_valid appears.
module tb_skew_monitor_ctrl;

   typedef struct {
      int value;
      bit viol;
      bit lead;
      int vc;
      int cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       enable;
   logic       a8, b8, a4, b4;
   logic       clear8, clear4;
   logic [7:0] limit8;
   logic [3:0] limit4;

   logic       v8, viol8, lb8, miss8;
   logic [7:0] val8, vc8;
   logic       v4, viol4, lb4, miss4;
   logic [3:0] val4;
   logic [7:0] vc4;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int miss8_n = 0;
   int miss4_n = 0;
   int m_vc8 = 0;
   int m_vc4 = 0;
   exp_t q8[$];
   exp_t q4[$];
   exp_t e8, e4;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   skew_monitor_ctrl #(.CNT_W(8), .VCNT_W(8)) dut8 (
      .clk        (clk),
      .reset_n    (reset_n),
      .enable     (enable),
      .sig_a      (a8),
      .sig_b      (b8),
      .limit      (limit8),
      .clear_cnt  (clear8),
      .skew_valid (v8),
      .skew_value (val8),
      .skew_viol  (viol8),
      .lead_b     (lb8),
      .miss_pulse (miss8),
      .viol_count (vc8)
   );

   skew_monitor_ctrl #(.CNT_W(4), .VCNT_W(8)) dut4 (
      .clk        (clk),
      .reset_n    (reset_n),
      .enable     (enable),
      .sig_a      (a4),
      .sig_b      (b4),
      .limit      (limit4),
      .clear_cnt  (clear4),
      .skew_valid (v4),
      .skew_value (val4),
      .skew_viol  (viol4),
      .lead_b     (lb4),
      .miss_pulse (miss4),
      .viol_count (vc4)
   );

   always @(negedge clk) begin
      if (reset_n === 1'b1) begin
         if (miss8 === 1'b1) miss8_n++;
         if (v8 === 1'b1) begin
            checks++;
            if (q8.size() == 0) begin
               errors++;
               $display("FAIL unexpected_valid8 cyc=%0d got value=%0d want no result", cyc, val8);
            end else begin
               e8 = q8.pop_front();
               if (cyc != e8.cyc) begin
                  errors++;
                  $display("FAIL latency8 got cyc=%0d want cyc=%0d", cyc, e8.cyc);
               end
               checks++;
               if (val8 !== 8'(e8.value)) begin
                  errors++;
                  $display("FAIL value8 got %0d want %0d", val8, e8.value);
               end
               checks++;
               if (viol8 !== e8.viol) begin
                  errors++;
                  $display("FAIL viol8 got %0b want %0b", viol8, e8.viol);
               end
               checks++;
               if (lb8 !== e8.lead) begin
                  errors++;
                  $display("FAIL lead_b8 got %0b want %0b", lb8, e8.lead);
               end
               checks++;
               if (vc8 !== 8'(e8.vc)) begin
                  errors++;
                  $display("FAIL viol_count8 got %0d want %0d", vc8, e8.vc);
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (reset_n === 1'b1) begin
         if (miss4 === 1'b1) miss4_n++;
         if (v4 === 1'b1) begin
            checks++;
            if (q4.size() == 0) begin
               errors++;
               $display("FAIL unexpected_valid4 cyc=%0d got value=%0d want no result", cyc, val4);
            end else begin
               e4 = q4.pop_front();
               if (cyc != e4.cyc) begin
                  errors++;
                  $display("FAIL latency4 got cyc=%0d want cyc=%0d", cyc, e4.cyc);
               end
               checks++;
               if (val4 !== 4'(e4.value)) begin
                  errors++;
                  $display("FAIL value4 got %0d want %0d", val4, e4.value);
               end
               checks++;
               if (viol4 !== e4.viol) begin
                  errors++;
                  $display("FAIL viol4 got %0b want %0b", viol4, e4.viol);
               end
               checks++;
               if (lb4 !== e4.lead) begin
                  errors++;
                  $display("FAIL lead_b4 got %0b want %0b", lb4, e4.lead);
               end
               checks++;
               if (vc4 !== 8'(e4.vc)) begin
                  errors++;
                  $display("FAIL viol_count4 got %0d want %0d", vc4, e4.vc);
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic exp8(input int value, input bit viol, input bit lead, input int dly);
      exp_t e;
      if (viol && m_vc8 < 255) m_vc8++;
      if (clear8) m_vc8 = 0;
      e.value = value; e.viol = viol; e.lead = lead; e.vc = m_vc8; e.cyc = cyc + dly;
      q8.push_back(e);
   endtask

   task automatic exp4(input int value, input bit viol, input bit lead, input int dly);
      exp_t e;
      if (viol && m_vc4 < 255) m_vc4++;
      e.value = value; e.viol = viol; e.lead = lead; e.vc = m_vc4; e.cyc = cyc + dly;
      q4.push_back(e);
   endtask

   // Opening edge, k cycles, closing edge; k=0 means both in the same cycle
   task automatic pair8(input bit b_lead, input int k);
      if (k == 0) begin
         a8 = 1'b1;
         b8 = 1'b1;
         exp8(0, 1'b0, 1'b0, 1);
      end else begin
         if (b_lead) b8 = 1'b1; else a8 = 1'b1;
         repeat (k) step();
         if (b_lead) a8 = 1'b1; else b8 = 1'b1;
         exp8(k, k > int'(limit8), b_lead, 1);
      end
      step();
      a8 = 1'b0;
      b8 = 1'b0;
      step();
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && (q8.size() != 0 || q4.size() != 0); i++) step();
      checks++;
      if (q8.size() != 0 || q4.size() != 0) begin
         errors++;
         $display("FAIL drain pending8=%0d pending4=%0d want 0", q8.size(), q4.size());
         q8.delete();
         q4.delete();
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; enable = 1'b1; clear8 = 1'b0; clear4 = 1'b0;
      a8 = 1'b1; b8 = 1'b1; a4 = 1'b1; b4 = 1'b1;
      limit8 = 8'd5; limit4 = 4'd15;
      repeat (3) step();
      reset_n = 1'b1;
      repeat (10) step();
      checks++; if (v8 !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", v8); end
      checks++; if (val8 !== 8'd0) begin errors++; $display("FAIL rst_value got %0d want 0", val8); end
      checks++; if (viol8 !== 1'b0) begin errors++; $display("FAIL rst_viol got %b want 0", viol8); end
      checks++; if (lb8 !== 1'b0) begin errors++; $display("FAIL rst_lead got %b want 0", lb8); end
      checks++; if (vc8 !== 8'd0) begin errors++; $display("FAIL rst_vcount got %0d want 0", vc8); end
      checks++; if (vc4 !== 8'd0) begin errors++; $display("FAIL rst_vcount4 got %0d want 0", vc4); end
      checks++;
      if (miss8_n != 0 || miss4_n != 0) begin
         errors++;
         $display("FAIL rst_miss got %0d/%0d want 0/0", miss8_n, miss4_n);
      end
      a8 = 1'b0; b8 = 1'b0; a4 = 1'b0; b4 = 1'b0;
      step(); step();
   endtask

   task automatic test_a_lead();
      limit8 = 8'd5;
      pair8(1'b0, 3);
      drain();
   endtask

   task automatic test_b_lead();
      pair8(1'b1, 7);
      drain();
   endtask

   task automatic test_same_cycle();
      pair8(1'b0, 0);
      drain();
   endtask

   task automatic test_limit_boundary();
      pair8(1'b0, 5);
      pair8(1'b1, 6);
      pair8(1'b1, 1);
      drain();
   endtask

   task automatic test_miss_timeout();
      int m0;
      m0 = miss4_n;
      a4 = 1'b1;
      step(); a4 = 1'b0;
      step(); step(); step();
      a4 = 1'b1;
      exp4(15, 1'b1, 1'b0, 16);
      step(); a4 = 1'b0;
      drain();
      checks++;
      if (miss4_n != m0 + 1) begin
         errors++;
         $display("FAIL miss_count got %0d want %0d", miss4_n - m0, 1);
      end
      b4 = 1'b1;
      exp4(15, 1'b1, 1'b1, 16);
      step(); b4 = 1'b0;
      drain();
      checks++;
      if (miss4_n != m0 + 1) begin
         errors++;
         $display("FAIL miss_b_timeout got %0d want %0d", miss4_n - m0, 1);
      end
   endtask

   task automatic test_enable();
      int m0;
      m0 = miss8_n;
      a8 = 1'b1;
      step(); step();
      enable = 1'b0;
      step();
      b8 = 1'b1;
      step(); step();
      enable = 1'b1;
      step();
      a8 = 1'b0; b8 = 1'b0;
      step(); step();
      pair8(1'b0, 2);
      drain();
      checks++;
      if (miss8_n != m0) begin
         errors++;
         $display("FAIL enable_miss got %0d want 0", miss8_n - m0);
      end
   endtask

   task automatic test_reset_abort();
      a8 = 1'b1;
      step(); step(); step();
      reset_n = 1'b0;
      m_vc8 = 0;
      m_vc4 = 0;
      step();
      reset_n = 1'b1;
      step();
      a8 = 1'b0;
      step(); step();
      checks++; if (vc8 !== 8'd0) begin errors++; $display("FAIL abort_vcount got %0d want 0", vc8); end
      pair8(1'b1, 4);
      drain();
   endtask

   task automatic test_back_to_back();
      a8 = 1'b1;
      step(); step();
      b8 = 1'b1;
      exp8(2, 1'b0, 1'b0, 1);
      step();
      a8 = 1'b0; b8 = 1'b0;
      step();
      b8 = 1'b1;
      step(); step();
      a8 = 1'b1;
      exp8(2, 1'b0, 1'b1, 1);
      step();
      a8 = 1'b0; b8 = 1'b0;
      step();
      // Closing B and a fresh A edge together: the new A must be ignored
      a8 = 1'b1;
      step(); a8 = 1'b0;
      step();
      a8 = 1'b1; b8 = 1'b1;
      exp8(2, 1'b0, 1'b0, 1);
      step();
      a8 = 1'b0; b8 = 1'b0;
      step();
      pair8(1'b1, 3);
      drain();
   endtask

   task automatic test_saturate_clear();
      limit8 = 8'd0;
      for (int i = 0; i < 300; i++) pair8(i[0], 1);
      drain();
      checks++;
      if (vc8 !== 8'd255) begin errors++; $display("FAIL saturate got %0d want 255", vc8); end
      a8 = 1'b1;
      step();
      b8 = 1'b1;
      clear8 = 1'b1;
      exp8(1, 1'b1, 1'b0, 1);
      step();
      clear8 = 1'b0;
      a8 = 1'b0; b8 = 1'b0;
      step();
      drain();
      checks++;
      if (vc8 !== 8'd0) begin errors++; $display("FAIL clear_wins got %0d want 0", vc8); end
      pair8(1'b0, 2);
      drain();
      limit8 = 8'd5;
   endtask

   initial begin
      test_reset();
      test_a_lead();
      test_b_lead();
      test_same_cycle();
      test_limit_boundary();
      test_miss_timeout();
      test_enable();
      test_reset_abort();
      test_back_to_back();
      test_saturate_clear();
      repeat (5) step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/skew_monitor_ctrl.md
# skew_monitor_ctrl

Synchronous skew-check controller that measures the distance, in system-clock cycles, between rising edges of two monitored strobes `sig_a` and `sig_b`. Each measured value is compared against a programmable limit, giving a pass/violation verdict per edge pair and a saturating violation count. It is the synthesizable, single-clock counterpart of the `$skew` timing check used in simulation. It sits beside the dual-flop capture datapath and sequences its skew checking.

## Interface
- `CNT_W`, 8: width of the skew counter, the limit and the result value.
- `VCNT_W`, 8: width of the saturating violation counter.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  monitor enable; low forces IDLE.
- `sig_a`  in  1  monitored strobe A, already synchronous to `clk`.
- `sig_b`  in  1  monitored strobe B, already synchronous to `clk`.
- `limit`  in  CNT_W  maximum allowed skew in cycles.
- `clear_cnt`  in  1  synchronous clear of `viol_count`.
- `skew_valid`  out  1  one-cycle result strobe.
- `skew_value`  out  CNT_W  measured skew, valid with `skew_valid`.
- `skew_viol`  out  1  violation flag, valid with `skew_valid`.
- `lead_b`  out  1  1 when B led A, valid with `skew_valid`.
- `miss_pulse`  out  1  one-cycle pulse when the leading strobe re-fires before the other strobe arrives.
- `viol_count`  out  VCNT_W  saturating count of violations.

## Operation
- Edge detection: `edge_x = sig_x & ~sig_x_q`. The first cycle after reset release is masked by a `primed` flag, so no edge is reported and strobes that are already high do not produce false edges.
- States: IDLE, ARMED_A (A led), ARMED_B (B led).
- IDLE:
  - `edge_a` alone goes to ARMED_A with cnt=1.
  - `edge_b` alone goes to ARMED_B with cnt=1.
  - Both edges in the same cycle produce a result with value 0, viol=0 and `lead_b`=0, and the FSM stays in IDLE.
- ARMED_A:
  - `edge_b` produces a result with value=cnt, `lead_b`=0, and the FSM goes to IDLE.
  - `edge_a` without `edge_b` pulses `miss_pulse`, reloads cnt=1 and stays in ARMED_A.
  - `edge_a` and `edge_b` together close the measurement with value=cnt. The new A edge is ignored.
  - With no edge, cnt increments.
  - If cnt reaches all-ones with no closing edge, the timeout produces a result with value=all-ones, viol=1, and the FSM goes to IDLE.
- ARMED_B mirrors ARMED_A with A and B swapped and `lead_b`=1.
- Verdict: `skew_viol` = (value > `limit`), strictly greater. A timeout always sets viol=1, even when `limit` is all-ones.
- `viol_count` increments on each result with viol=1 and saturates at all-ones. If `clear_cnt` coincides with a violation, `clear_cnt` wins and the count becomes 0.
- `enable`=0: FSM returns to IDLE next cycle, cnt clears, and no results or miss pulses are produced. Edge registers keep tracking, so re-enabling does not create false edges.

## Timing
- Reset values: state=IDLE, cnt=0, `primed`=0, `sig_*_q`=0, and all outputs 0 (`skew_value`=0, `viol_count`=0).
- Outputs are registered. `skew_valid`, `skew_value`, `skew_viol` and `lead_b` update the cycle after the closing edge is detected.
- `skew_valid` is high for exactly one cycle per measurement.
- `skew_value`, `skew_viol` and `lead_b` hold their last values until the next result.
- `viol_count` updates in the same cycle as the `skew_valid` that carries the violation.
- Edge cycle: an edge on `sig_x` at cycle n means `sig_x` sampled 1 at cycle n and 0 at cycle n-1. Opening edge at n and closing edge at n+k gives value=k.
- Reset asserted mid-measurement aborts immediately. No result is produced for the aborted pair.

## Structure
- Package `skew_mon_pkg`: state encoding constants (`S_IDLE`=2'd0, `S_ARMED_A`=2'd1, `S_ARMED_B`=2'd2), and default `CNT_W`/`VCNT_W`.
- Sub-module `edge_detect_prime`: previous-value register, `primed` mask, rising-edge output. Instantiated twice, once for A and once for B.
- FSM, counter, comparator and violation counter live in the top module.

## Test plan
- Reset release with `sig_a`=`sig_b`=1 already high, `limit`=5 -> no `skew_valid` and no `miss_pulse` for 10 cycles. All outputs stay 0.
- A rises at cycle 10, B rises at cycle 13, `limit`=5 -> `skew_valid` at cycle 14, value=3, viol=0, `lead_b`=0, `viol_count`=0.
- B rises at cycle 20, A rises at cycle 27, `limit`=5 -> value=7, viol=1, `lead_b`=1, `viol_count`=1.
- A and B rise in the same cycle -> value=0, viol=0, `lead_b`=0.
- `CNT_W`=4, A rises and B never rises -> `skew_valid` with value=15 and viol=1 after timeout. A second A edge before timeout gives one `miss_pulse` and restarts the count.
- Drive 300 violations with `VCNT_W`=8 -> `viol_count` saturates at 255. Then assert `clear_cnt` in the same cycle as a violation -> `viol_count`=0.
